tx_event_scheduler: RTL and testbench

TX_EVENT_SCHEDULER -- requirements
Module: tx_event_scheduler

---
 rtl/tx_event_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_tx_event_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_event_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tx_event_scheduler
//
// Collects cardiac activation/pace events into a small FIFO of
// {header, timestamp} frames and hands them one at a time to a serial
// transmitter. Each frame is started with a one-cycle tx_go and is
// finished by the transmitter's tx_done pulse or by a timeout. An
// optional idle gap separates a completed frame from the next start.
//
// Parameters
//   DEPTH    FIFO entries (power of 2, >= 2)
//   TIMEOUT  max cycles spent waiting for tx_done (>= 1)
//   GAP      idle cycles after tx_done before the next frame (0 allowed)
//
// Ports
//   clk          in   rising-edge clock for all logic
//   rst_n        in   synchronous active-low reset
//   na1_ev       in   SA-node activation pulse          (atrial group)
//   apace_ev     in   atrial pace pulse                 (atrial group)
//   na3_ev       in   ventricular-node activation pulse (ventricular group)
//   vpace_ev     in   ventricular pace pulse            (ventricular group)
//   counter      in   free-running 32-bit timestamp
//   tx_done      in   transmitter frame-complete pulse
//   tx_go        out  one-cycle transmit start
//   tx_header    out  header of the frame being sent
//   tx_counter   out  timestamp of the frame being sent
//   level        out  FIFO occupancy
//   busy         out  a frame is in flight (GO/WAIT/HOLD)
//   drop_count   out  saturating count of events lost to a full FIFO
//   timeout_err  out  sticky flag, set when tx_done never arrived
// ---------------------------------------------------------------------------
module tx_event_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023,
    parameter int GAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     na1_ev,
    input  logic                     apace_ev,
    input  logic                     na3_ev,
    input  logic                     vpace_ev,
    input  logic [31:0]              counter,
    input  logic                     tx_done,
    output logic                     tx_go,
    output logic [7:0]               tx_header,
    output logic [31:0]              tx_counter,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic [7:0]               drop_count,
    output logic                     timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GO   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // With no gap configured a completed frame goes straight back to IDLE.
    localparam logic [1:0] S_AFTER_DONE = (GAP > 0) ? S_HOLD : S_IDLE;

    logic [39:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_dropCount;

    logic [1:0]    r_state;
    logic [TW-1:0] r_tmoCnt;
    logic [GW-1:0] r_gapCnt;
    logic [7:0]    r_txHeader;
    logic [31:0]   r_txCounter;
    logic          r_timeoutErr;

    logic          w_aValid;
    logic          w_vValid;
    logic [7:0]    w_aHeader;
    logic [7:0]    w_vHeader;
    logic [LW-1:0] w_free;
    logic          w_pushA;
    logic          w_pushV;
    logic [1:0]    w_pushCount;
    logic [1:0]    w_drops;
    logic [8:0]    w_dropSum;
    logic          w_pop;
    logic [PW-1:0] w_vAddr;
    logic [LW-1:0] w_levelNext;
    logic [TW-1:0] w_tmoNext;

    // Atrial headers are 1..3 and ventricular headers 4..6; the two-bit
    // event pair maps directly onto the low bits of the code.
    assign w_aValid  = na1_ev | apace_ev;
    assign w_vValid  = na3_ev | vpace_ev;
    assign w_aHeader = {6'd0, apace_ev, na1_ev};
    assign w_vHeader = 8'd3 + {6'd0, vpace_ev, na3_ev};

    // Space is judged from the occupancy at the start of the cycle, so a
    // pop in the same cycle never makes room. The atrial entry has first
    // claim on a single free slot.
    assign w_free      = LW'(DEPTH) - r_level;
    assign w_pushA     = w_aValid && (w_free != '0);
    assign w_pushV     = w_vValid && (w_aValid ? (w_free >= LW'(2)) : (w_free != '0));
    assign w_pushCount = {1'b0, w_pushA} + {1'b0, w_pushV};
    assign w_drops     = {1'b0, w_aValid & ~w_pushA} + {1'b0, w_vValid & ~w_pushV};
    assign w_dropSum   = {1'b0, r_dropCount} + {7'd0, w_drops};
    assign w_vAddr     = r_wrPtr + PW'(w_pushA);

    assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
    assign w_levelNext = r_level + LW'(w_pushCount) - LW'(w_pop);
    assign w_tmoNext   = r_tmoCnt + TW'(1);

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_pushA) begin
                r_mem[r_wrPtr] <= {w_aHeader, counter};
            end
            if (w_pushV) begin
                r_mem[w_vAddr] <= {w_vHeader, counter};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_level     <= '0;
            r_dropCount <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + PW'(w_pushCount);
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_level <= w_levelNext;
            if (w_dropSum > 9'd255) begin
                r_dropCount <= 8'd255;
            end else begin
                r_dropCount <= w_dropSum[7:0];
            end
        end
    end

    // Frame sequencer. tx_done is honoured in GO as well as WAIT so a very
    // fast transmitter is not mistaken for a timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmoCnt     <= '0;
            r_gapCnt     <= '0;
            r_txHeader   <= '0;
            r_txCounter  <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_txHeader, r_txCounter} <= r_mem[r_rdPtr];
                        r_state <= S_GO;
                    end
                end
                S_GO: begin
                    r_tmoCnt <= '0;
                    r_gapCnt <= '0;
                    if (tx_done) begin
                        r_state <= S_AFTER_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        r_gapCnt <= '0;
                        r_state  <= S_AFTER_DONE;
                    end else if (w_tmoNext == TMO_LIMIT) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_tmoCnt <= w_tmoNext;
                    end
                end
                S_HOLD: begin
                    if (r_gapCnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_go       = (r_state == S_GO);
    assign busy        = (r_state != S_IDLE);
    assign tx_header   = r_txHeader;
    assign tx_counter  = r_txCounter;
    assign level       = r_level;
    assign drop_count  = r_dropCount;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_tx_event_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tx_event_scheduler
//
// Directed bench for tx_event_scheduler (DEPTH=4, TIMEOUT=8, GAP=1).
// Stimulus pushes the hand-derived frame each event must produce into a
// scoreboard queue; a monitor pops and compares on every tx_go. A
// responder process can answer tx_go with tx_done after a set delay.
// ---------------------------------------------------------------------------
module tb_tx_event_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int GAP     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        na1_ev;
    logic        apace_ev;
    logic        na3_ev;
    logic        vpace_ev;
    logic [31:0] counter;
    logic        tx_done;
    logic        rspDone;
    logic        manDone;
    logic        tx_go;
    logic [7:0]  tx_header;
    logic [31:0] tx_counter;
    logic [2:0]  level;
    logic        busy;
    logic [7:0]  drop_count;
    logic        timeout_err;

    int          checkCount = 0;
    int          failCount  = 0;
    int          goCount    = 0;
    logic [39:0] expQ [$];
    logic [39:0] expFrame;
    logic        autoDone   = 1'b0;
    int          doneDelay  = 2;
    time         lastDoneT  = 0;
    time         lastGoT    = 0;

    logic [3:0]  wrapPat [10] = '{4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b0001,
                                  4'b0011, 4'b1000, 4'b0011, 4'b0100, 4'b0001};
    logic [7:0]  wrapHdr [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                                  8'd6, 8'd1, 8'd6, 8'd2, 8'd5};

    assign tx_done = rspDone | manDone;

    tx_event_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .na1_ev      (na1_ev),
        .apace_ev    (apace_ev),
        .na3_ev      (na3_ev),
        .vpace_ev    (vpace_ev),
        .counter     (counter),
        .tx_done     (tx_done),
        .tx_go       (tx_go),
        .tx_header   (tx_header),
        .tx_counter  (tx_counter),
        .level       (level),
        .busy        (busy),
        .drop_count  (drop_count),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; the event is seen at the next rise.
    task automatic applyStimulus(input logic a1, input logic ap, input logic a3,
                                 input logic vp, input logic [31:0] cnt);
        na1_ev   = a1;
        apace_ev = ap;
        na3_ev   = a3;
        vpace_ev = vp;
        counter  = cnt;
        @(negedge clk);
        na1_ev   = 1'b0;
        apace_ev = 1'b0;
        na3_ev   = 1'b0;
        vpace_ev = 1'b0;
    endtask

    task automatic waitGo(input int maxCycles, input string name, output int cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_go !== 1'b1 && n < maxCycles);
        lastGoT = $time - 5;
        cycles  = n;
        checkOutput(name, 32'(tx_go), 32'd1);
    endtask

    task automatic waitIdle(input int maxCycles, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || level !== 3'd0) && n < maxCycles);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_level"}, 32'(level), 32'd0);
    endtask

    // Scoreboard monitor: every tx_go must match the oldest expected frame.
    initial forever begin
        @(negedge clk);
        if (tx_go === 1'b1) begin
            goCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_tx_go", 32'(tx_go), 32'd0);
            end else begin
                expFrame = expQ.pop_front();
                checkOutput("frame_header", 32'(tx_header), 32'(expFrame[39:32]));
                checkOutput("frame_counter", tx_counter, expFrame[31:0]);
            end
        end
    end

    // Transmitter model answering tx_go after doneDelay falling edges.
    initial begin
        rspDone = 1'b0;
        forever begin
            @(negedge clk);
            if (autoDone && tx_go === 1'b1) begin
                repeat (doneDelay) @(negedge clk);
                rspDone = 1'b1;
                @(negedge clk);
                rspDone = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (tx_done === 1'b1) lastDoneT = $time;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        int g;
        rst_n    = 1'b0;
        na1_ev   = 1'b0;
        apace_ev = 1'b0;
        na3_ev   = 1'b0;
        vpace_ev = 1'b0;
        counter  = 32'd0;
        manDone  = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset_tx_go", 32'(tx_go), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_header", 32'(tx_header), 32'd0);
        checkOutput("reset_counter", tx_counter, 32'd0);
        checkOutput("reset_drops", 32'(drop_count), 32'd0);
        checkOutput("reset_tmo_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single na1 event at counter 100.
        autoDone  = 1'b1;
        doneDelay = 2;
        expQ.push_back({8'd1, 32'd100});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd100);
        checkOutput("single_level_push", 32'(level), 32'd1);
        checkOutput("single_busy_before", 32'(busy), 32'd0);
        waitGo(10, "single_go", n);
        checkOutput("single_go_latency", 32'(n), 32'd1);
        checkOutput("single_level_pop", 32'(level), 32'd0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        waitIdle(50, "single_idle");
        checkOutput("single_header_hold", 32'(tx_header), 32'd1);
        checkOutput("single_counter_hold", tx_counter, 32'd100);

        // na1 + apace + vpace together at counter 7.
        expQ.push_back({8'd3, 32'd7});
        expQ.push_back({8'd5, 32'd7});
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'd7);
        checkOutput("dual_level_push", 32'(level), 32'd2);
        waitGo(10, "dual_go_first", n);
        checkOutput("dual_level_after_first", 32'(level), 32'd1);
        waitGo(40, "dual_go_second", n);
        checkOutput("dual_gap_ns", 32'(lastGoT - lastDoneT), 32'd20);
        waitIdle(50, "dual_idle");

        // Overflow with tx_done held low.
        autoDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expQ.push_back({8'd1, 32'(201 + i)});
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'(201 + i));
        end
        checkOutput("ovf_level_full", 32'(level), 32'd4);
        checkOutput("ovf_drops_one", 32'(drop_count), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd300);
        checkOutput("ovf_level_still_full", 32'(level), 32'd4);
        checkOutput("ovf_drops_three", 32'(drop_count), 32'd3);
        manDone = 1'b1;
        @(negedge clk);
        manDone = 1'b0;
        waitGo(10, "ovf_go_after_done", n);
        checkOutput("ovf_level_one_free", 32'(level), 32'd3);
        expQ.push_back({8'd1, 32'd400});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd400);
        checkOutput("ovf_level_refill", 32'(level), 32'd4);
        checkOutput("ovf_drops_vent_only", 32'(drop_count), 32'd4);

        // Same frame left unanswered: times out after TIMEOUT WAIT cycles.
        checkOutput("tmo_err_before", 32'(timeout_err), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (timeout_err !== 1'b1 && n < 20);
        checkOutput("tmo_wait_cycles", 32'(n), 32'd8);
        checkOutput("tmo_err_set", 32'(timeout_err), 32'd1);
        checkOutput("tmo_busy_idle", 32'(busy), 32'd0);
        autoDone  = 1'b1;
        doneDelay = 2;
        waitGo(5, "tmo_next_frame", n);
        checkOutput("tmo_next_latency", 32'(n), 32'd1);
        checkOutput("tmo_next_level", 32'(level), 32'd3);
        waitIdle(200, "ovf_drain");
        checkOutput("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Reset while a frame is in WAIT with three more queued.
        autoDone = 1'b0;
        expQ.push_back({8'd1, 32'd501});
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'(501 + i));
        end
        checkOutput("rst_pre_level", 32'(level), 32'd3);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd999);
        rst_n = 1'b1;
        checkOutput("rst_mid_tx_go", 32'(tx_go), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_level", 32'(level), 32'd0);
        checkOutput("rst_mid_header", 32'(tx_header), 32'd0);
        checkOutput("rst_mid_counter", tx_counter, 32'd0);
        checkOutput("rst_mid_drops", 32'(drop_count), 32'd0);
        checkOutput("rst_mid_tmo_err", 32'(timeout_err), 32'd0);
        g = goCount;
        manDone = 1'b1;
        @(negedge clk);
        manDone = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("late_done_no_go", 32'(goCount - g), 32'd0);
        checkOutput("late_done_busy", 32'(busy), 32'd0);

        // Ten frames wrapping the pointers; tx_done answered inside GO.
        autoDone  = 1'b1;
        doneDelay = 0;
        for (int i = 0; i < 10; i++) begin
            expQ.push_back({wrapHdr[i], 32'(2000 + 17 * i)});
            applyStimulus(wrapPat[i][3], wrapPat[i][2], wrapPat[i][1], wrapPat[i][0],
                          32'(2000 + 17 * i));
            n = 0;
            while (level >= 3'd3 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        waitIdle(300, "wrap_idle");
        checkOutput("wrap_drops", 32'(drop_count), 32'd0);
        checkOutput("wrap_tmo_err", 32'(timeout_err), 32'd0);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        checkOutput("total_frames", 32'(goCount), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
